simon_seq_mem: RTL and testbench
================================

# simon_seq_mem

Parametrised sequence store for the Simon Says core. It holds up to DEPTH colour symbols of SYM_W bits and replaces the fixed 32-bit byte-loaded register. It adds a tracked sequence length, append-at-tail writes, a playback/check pointer that compares player input against the stored pattern, and overflow/match status pulses. Bulk lane loads and the test-bench full-word override are kept, so the existing controller and benches still work at default parameters.

## Interface
- SYM_W, 2, bits per symbol (colour code)
- DEPTH, 16, max symbols; TOTAL = SYM_W*DEPTH (32 at defaults)
- LANE_W, 8, bulk-load lane width; TOTAL must be a multiple of LANE_W; LANES = TOTAL/LANE_W
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of contents, length and pointer
- test_load  in  1  bench override: load whole store
- test_data  in  TOTAL  override data
- lane_load  in  1  write one lane
- lane_sel  in  clog2(LANES)  lane index; lane k = bits [k*LANE_W +: LANE_W]
- lane_data  in  LANE_W  lane write data
- append  in  1  write append_sym at index seq_len
- append_sym  in  SYM_W  symbol to append
- ptr_rst  in  1  pointer to 0
- ptr_next  in  1  advance pointer (playback)
- chk_valid  in  1  player symbol present
- chk_sym  in  SYM_W  player symbol
- mem_out  out  TOTAL  full store; symbol i = bits [i*SYM_W +: SYM_W]
- seq_len  out  clog2(DEPTH+1)  stored symbol count
- full  out  1  seq_len == DEPTH
- ptr  out  clog2(DEPTH)  current pointer
- ptr_sym  out  SYM_W  symbol at ptr (combinational from registers)
- ptr_last  out  1  seq_len != 0 and ptr == seq_len-1
- chk_ok, chk_err, chk_done, overflow  out  1 each  registered one-cycle pulses

## Operation
- Store write priority (one winner per cycle): clr > test_load > lane_load > append.
  - clr: store = 0, seq_len = 0.
  - test_load: store = test_data, seq_len = DEPTH.
  - lane_load: selected lane only; seq_len unchanged.
  - append, not full: symbol[seq_len] = append_sym, seq_len++.
  - append when full: no write; overflow pulses.
- Pointer priority: clr > ptr_rst > chk_valid > ptr_next; all set ptr = 0 except as below.
  - ptr_next: ptr++, wrapping to 0 after seq_len-1; ptr stays 0 while seq_len == 0.
  - chk_valid, seq_len == 0: chk_err; ptr = 0.
  - chk_valid, chk_sym == symbol[ptr]: chk_ok. If ptr_last, chk_done and ptr = 0; else ptr++.
  - chk_valid, mismatch: chk_err; ptr = 0.
- Checks compare against pre-edge contents. Same-cycle append or lane_load do not affect the current compare.
- If clr is asserted, no chk_* pulse is generated that cycle; overflow is also suppressed.
- If a write reduces seq_len below ptr+1 (clr only), ptr is already forced to 0.

## Timing
- rst_n low: immediately and asynchronously, every register and output goes to 0 (mem_out, seq_len, ptr, all pulses). ptr_sym = symbol[0] = 0; full = 0; ptr_last = 0.
- Operation resumes on the first rising clk edge after rst_n deasserts. Reset mid-append or mid-check discards that operation.
- All writes and pointer updates take effect at the rising edge of the cycle their input is sampled. mem_out, seq_len, ptr, full, ptr_sym and ptr_last reflect the update immediately after that edge.
- chk_ok/chk_err/chk_done/overflow are registered. They are high for exactly the one cycle after the sampling edge. Back-to-back chk_valid cycles produce back-to-back pulses.
- No handshake back-pressure; every input is accepted each cycle it is asserted.

## Test plan
- Reset: drive traffic, pull rst_n low mid-cycle -> all outputs 0 without a clk edge; release, idle -> seq_len 0, full 0.
- Lane load: lane_load, lane_sel=2, lane_data=0xA5 -> mem_out 0x00A50000, seq_len 0. Same cycle with test_load=1, test_data=0xDEADBEEF -> mem_out 0xDEADBEEF, seq_len 16.
- Append and play back: append 3,1,2 -> seq_len 3, mem_out[5:0]=6'b100111. ptr_rst, then ptr_next x3 -> ptr_sym 3,1,2, ptr_last high on 2, wraps to ptr 0.
- Check pass: after the above, chk_sym 3,1,2 on consecutive cycles -> chk_ok x3, chk_done only with the third, ptr ends 0.
- Check fail / empty: chk_sym 3 then 0 -> chk_ok then chk_err, ptr 0. After clr, chk_valid -> chk_err, no chk_ok.
- Overflow and priority: append 17 times -> full after the 16th; the 17th pulses overflow with mem_out unchanged. clr with test_load and chk_valid in the same cycle -> mem_out 0, seq_len 0, no chk pulse.

Source files
------------

// File: rtl/simon_seq_mem.sv
// simon_seq_mem: Simon Says sequence store with append, bulk loads, playback pointer and player check
module simon_seq_mem #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 16,
  parameter int LANE_W = 8,
  localparam int TOTAL = SYM_W * DEPTH,
  localparam int LANES = TOTAL / LANE_W,
  localparam int LSW = LANES > 1 ? $clog2(LANES) : 1,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             test_load,
  input  logic [TOTAL-1:0] test_data,
  input  logic             lane_load,
  input  logic [LSW-1:0]   lane_sel,
  input  logic [LANE_W-1:0] lane_data,
  input  logic             append,
  input  logic [SYM_W-1:0] append_sym,
  input  logic             ptr_rst,
  input  logic             ptr_next,
  input  logic             chk_valid,
  input  logic [SYM_W-1:0] chk_sym,
  output logic [TOTAL-1:0] mem_out,
  output logic [LW-1:0]    seq_len,
  output logic             full,
  output logic [PW-1:0]    ptr,
  output logic [SYM_W-1:0] ptr_sym,
  output logic             ptr_last,
  output logic             chk_ok,
  output logic             chk_err,
  output logic             chk_done,
  output logic             overflow
);
  logic [TOTAL-1:0] mem_nxt;
  logic [LW-1:0]    len_nxt;
  logic [PW-1:0]    ptr_nxt;
  logic             ovf_nxt, ok_nxt, err_nxt, done_nxt;
  assign full     = seq_len == LW'(DEPTH);
  assign ptr_sym  = mem_out[ptr*SYM_W +: SYM_W];
  assign ptr_last = seq_len != '0 && LW'(ptr) == seq_len - 1'b1;
  always_comb begin
    mem_nxt = mem_out;
    len_nxt = seq_len;
    ovf_nxt = 1'b0;
    if (clr) begin
      mem_nxt = '0;
      len_nxt = '0;
    end else if (test_load) begin
      mem_nxt = test_data;
      len_nxt = LW'(DEPTH);
    end else if (lane_load)
      mem_nxt[lane_sel*LANE_W +: LANE_W] = lane_data;
    else if (append && full)
      ovf_nxt = 1'b1;
    else if (append) begin
      mem_nxt[seq_len*SYM_W +: SYM_W] = append_sym;
      len_nxt = seq_len + 1'b1;
    end
  end
  // compares use ptr_sym, i.e. the store as it stood before this edge
  always_comb begin
    ptr_nxt  = ptr;
    ok_nxt   = 1'b0;
    err_nxt  = 1'b0;
    done_nxt = 1'b0;
    if (clr || ptr_rst)
      ptr_nxt = '0;
    else if (chk_valid) begin
      ok_nxt   = seq_len != '0 && chk_sym == ptr_sym;
      err_nxt  = !ok_nxt;
      done_nxt = ok_nxt && ptr_last;
      ptr_nxt  = ok_nxt && !ptr_last ? ptr + 1'b1 : '0;
    end else if (ptr_next)
      ptr_nxt = seq_len == '0 || ptr_last ? '0 : ptr + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_out  <= '0;
      seq_len  <= '0;
      ptr      <= '0;
      chk_ok   <= 1'b0;
      chk_err  <= 1'b0;
      chk_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      mem_out  <= mem_nxt;
      seq_len  <= len_nxt;
      ptr      <= ptr_nxt;
      chk_ok   <= ok_nxt;
      chk_err  <= err_nxt;
      chk_done <= done_nxt;
      overflow <= ovf_nxt;
    end
  end
endmodule

// File: tb/tb_simon_seq_mem.sv
// tb_simon_seq_mem: randomized and directed checks of simon_seq_mem against a symbol-array model
module tb_simon_seq_mem;
  logic        clk = 0, rst_n = 0;
  logic        clr, test_load, lane_load, append, ptr_rst, ptr_next, chk_valid;
  logic [31:0] test_data;
  logic [1:0]  lane_sel, append_sym, chk_sym;
  logic [7:0]  lane_data;
  logic [31:0] mem_out;
  logic [4:0]  seq_len;
  logic [3:0]  ptr;
  logic [1:0]  ptr_sym;
  logic        full, ptr_last, chk_ok, chk_err, chk_done, overflow;
  int total = 0, bad = 0;
  int sym[16];
  int len, p, l0, p0, cs, bp;
  bit last, e_ok, e_err, e_done, e_ovf;
  logic [31:0] saved;
  simon_seq_mem dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .test_load(test_load), .test_data(test_data),
    .lane_load(lane_load), .lane_sel(lane_sel), .lane_data(lane_data),
    .append(append), .append_sym(append_sym), .ptr_rst(ptr_rst), .ptr_next(ptr_next),
    .chk_valid(chk_valid), .chk_sym(chk_sym), .mem_out(mem_out), .seq_len(seq_len),
    .full(full), .ptr(ptr), .ptr_sym(ptr_sym), .ptr_last(ptr_last),
    .chk_ok(chk_ok), .chk_err(chk_err), .chk_done(chk_done), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (sym[i]) sym[i] = 0;
      len = 0; p = 0;
      {e_ok, e_err, e_done, e_ovf} = '0;
    end else begin
      l0 = len; p0 = p; cs = sym[p];
      {e_ok, e_err, e_done, e_ovf} = '0;
      if (clr) begin
        foreach (sym[i]) sym[i] = 0;
        len = 0;
      end else if (test_load) begin
        for (int i = 0; i < 16; i++) sym[i] = (test_data >> (2 * i)) & 3;
        len = 16;
      end else if (lane_load) begin
        for (int b = 0; b < 8; b++) begin
          bp = lane_sel * 8 + b;
          sym[bp / 2] = (sym[bp / 2] & ~(1 << (bp % 2))) | (int'(lane_data[b]) << (bp % 2));
        end
      end else if (append) begin
        if (l0 == 16) e_ovf = 1;
        else begin
          sym[l0] = append_sym;
          len = l0 + 1;
        end
      end
      last = l0 > 0 && p0 == l0 - 1;
      if (clr || ptr_rst) p = 0;
      else if (chk_valid) begin
        if (l0 > 0 && chk_sym == cs) begin
          e_ok = 1;
          e_done = last;
          p = last ? 0 : p0 + 1;
        end else begin
          e_err = 1;
          p = 0;
        end
      end else if (ptr_next) p = (l0 == 0 || last) ? 0 : p0 + 1;
    end
  end
  always @(negedge clk) begin
    logic [31:0] em;
    em = 0;
    for (int i = 0; i < 16; i++) em = em | (32'(sym[i]) << (2 * i));
    chk("mem_out", mem_out, em);
    chk("seq_len", 32'(seq_len), 32'(len));
    chk("full", 32'(full), 32'(len == 16));
    chk("ptr", 32'(ptr), 32'(p));
    chk("ptr_sym", 32'(ptr_sym), 32'(sym[p]));
    chk("ptr_last", 32'(ptr_last), 32'(len > 0 && p == len - 1));
    chk("pulses", {28'd0, chk_ok, chk_err, chk_done, overflow}, {28'd0, e_ok, e_err, e_done, e_ovf});
  end
  task automatic idle();
    {clr, test_load, lane_load, append, ptr_rst, ptr_next, chk_valid} = '0;
    test_data = 0; lane_sel = 0; lane_data = 0; append_sym = 0; chk_sym = 0;
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  initial begin
    idle();
    repeat (3) step();
    chk("reset mem", mem_out, 0);
    chk("reset len", 32'(seq_len), 0);
    rst_n = 1;
    step();
    chk("idle full", 32'(full), 0);
    lane_load = 1; lane_sel = 2; lane_data = 8'hA5;
    step();
    chk("lane mem", mem_out, 32'h00A50000);
    chk("lane len", 32'(seq_len), 0);
    test_load = 1; test_data = 32'hDEADBEEF;
    step();
    chk("tload mem", mem_out, 32'hDEADBEEF);
    chk("tload len", 32'(seq_len), 16);
    idle(); clr = 1; step();
    idle(); append = 1; append_sym = 3; step();
    append_sym = 1; step();
    append_sym = 2; step();
    chk("app len", 32'(seq_len), 3);
    chk("app bits", 32'(mem_out[5:0]), 32'b100111);
    idle(); ptr_rst = 1; step();
    chk("play0", 32'(ptr_sym), 3);
    idle(); ptr_next = 1; step();
    chk("play1", 32'(ptr_sym), 1);
    step();
    chk("play2", 32'(ptr_sym), 2);
    chk("play2 last", 32'(ptr_last), 1);
    step();
    chk("play wrap", 32'(ptr), 0);
    idle(); chk_valid = 1; chk_sym = 3; step();
    chk("pass1", {30'd0, chk_ok, chk_done}, 32'b10);
    chk_sym = 1; step();
    chk("pass2", {30'd0, chk_ok, chk_done}, 32'b10);
    chk_sym = 2; step();
    chk("pass3", {30'd0, chk_ok, chk_done}, 32'b11);
    chk("pass ptr", 32'(ptr), 0);
    chk_sym = 3; step();
    chk("fail ok", 32'(chk_ok), 1);
    chk_sym = 0; step();
    chk("fail err", {30'd0, chk_ok, chk_err}, 32'b01);
    chk("fail ptr", 32'(ptr), 0);
    idle(); clr = 1; step();
    idle(); chk_valid = 1; step();
    chk("empty err", {30'd0, chk_ok, chk_err}, 32'b01);
    idle(); clr = 1; step();
    idle(); append = 1;
    for (int i = 0; i < 16; i++) begin
      append_sym = 2'(i);
      step();
      if (i == 14) chk("not full", 32'(full), 0);
    end
    chk("full16", 32'(full), 1);
    saved = mem_out;
    append_sym = 3; step();
    chk("ovf", 32'(overflow), 1);
    chk("ovf mem", mem_out, saved);
    idle(); clr = 1; test_load = 1; test_data = 32'hFFFF_FFFF; chk_valid = 1; step();
    chk("prio mem", mem_out, 0);
    chk("prio len", 32'(seq_len), 0);
    chk("prio pulses", {30'd0, chk_ok, chk_err}, 0);
    idle(); test_load = 1; test_data = 32'h1234_5678; step();
    idle(); ptr_next = 1; append = 1; chk_valid = 1; chk_sym = 0;
    #2 rst_n = 0;
    #1;
    chk("async mem", mem_out, 0);
    chk("async len", 32'(seq_len), 0);
    chk("async ptr", {27'd0, ptr, ptr_last}, 0);
    #1 rst_n = 1;
    idle(); step();
    chk("post rst len", 32'(seq_len), 0);
    chk("post rst full", 32'(full), 0);
    for (int n = 0; n < 3000; n++) begin
      idle();
      clr       = $urandom_range(0, 39) == 0;
      test_load = $urandom_range(0, 29) == 0;
      test_data = $urandom;
      lane_load = $urandom_range(0, 9) == 0;
      lane_sel  = 2'($urandom);
      lane_data = 8'($urandom);
      append    = $urandom_range(0, 2) == 0;
      append_sym = 2'($urandom);
      ptr_rst   = $urandom_range(0, 19) == 0;
      ptr_next  = $urandom_range(0, 3) == 0;
      chk_valid = !ptr_rst && $urandom_range(0, 2) == 0;
      chk_sym   = $urandom_range(0, 2) != 0 ? 2'(sym[p]) : 2'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
